md_sequencer: RTL and testbench

//  Multi-cycle multiply/divide sequencer sitting in EX beside the combinational ALU.

---
 rtl/md_pkg.sv | 32 +++
 rtl/md_arith.sv | 56 +++++
 rtl/md_sequencer.sv | 119 +++++++++++
 tb/tb_md_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_pkg;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } mdop_e;

  // IDLE <=> busy==0, RUN <=> busy==1
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the sequencer for a multi-cycle run
  function automatic logic is_long_op(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit multiply/divide result generator.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencer samples the result on accept.
// Ports: mdop (op select), numa/numb (rs/rt operands),
//        res_hi/res_lo (product halves or remainder/quotient), div_zero.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  mdop,
  input  logic [31:0] numa,
  input  logic [31:0] numb,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic [31:0]        sq, sr, uq, ur;

  assign smul = $signed({{32{numa[31]}}, numa}) * $signed({{32{numb[31]}}, numb});
  assign umul = {32'd0, numa} * {32'd0, numb};

  always_comb begin
    sq = 32'd0;
    sr = 32'd0;
    uq = 32'd0;
    ur = 32'd0;
    if (numb != 32'd0) begin
      uq = numa / numb;
      ur = numa % numb;
      // Most-negative / -1 overflows; pin it to the hardware-typical wrap.
      if (numa == 32'h8000_0000 && numb == 32'hFFFF_FFFF) begin
        sq = 32'h8000_0000;
        sr = 32'd0;
      end else begin
        sq = $signed(numa) / $signed(numb);
        sr = $signed(numa) % $signed(numb);
      end
    end
  end

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = (numb == 32'd0);
    case (mdop)
      MD_MULT:  begin res_hi = smul[63:32]; res_lo = smul[31:0]; end
      MD_MULTU: begin res_hi = umul[63:32]; res_lo = umul[31:0]; end
      MD_DIV:   begin res_hi = sr;          res_lo = sq;         end
      MD_DIVU:  begin res_hi = ur;          res_lo = uq;         end
      default:  ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer holding HI/LO, with decode stall request.
// Latency: MULT N=MULT_CYCLES, DIV N=DIV_CYCLES busy cycles; result at t+N+1. MTHI/MTLO 1 edge.
// Backpressure: start ignored while busy; stall freezes ID while an md instr must wait.
// Ports: clk, reset (sync, active-low), start/mdop/numa/numb (EX command),
//        md_req (ID has md-class instr), busy, stall, hi, lo.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] numa,
  input  logic [31:0] numb,
  input  logic        md_req,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] ar_hi, ar_lo;
  logic        ar_dz;

  md_arith u_arith (
    .mdop     (mdop),
    .numa     (numa),
    .numb     (numb),
    .res_hi   (ar_hi),
    .res_lo   (ar_lo),
    .div_zero (ar_dz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        // Being idle is the accept condition; operands are latched here only.
        if (start) begin
          case (mdop)
            MD_MULT, MD_MULTU: begin
              pend_hi_d = ar_hi;
              pend_lo_d = ar_lo;
              dz_d      = 1'b0;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = ar_hi;
              pend_lo_d = ar_lo;
              dz_d      = ar_dz;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = ST_RUN;
            end
            MD_MTHI: hi_d = numa;
            MD_MTLO: lo_d = numa;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        // Final busy cycle: commit (unless divide-by-zero) and drop busy together.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;
  // Also stalls in the issue cycle so the follower never sees pre-commit HI/LO.
  assign stall = md_req & (busy | (start & is_long_op(mdop)));

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic [2:0]  mdop   = 3'd6;
  logic [31:0] numa   = 32'd0;
  logic [31:0] numb   = 32'd0;
  logic        md_req = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  md_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdop   (mdop),
    .numa   (numa),
    .numb   (numb),
    .md_req (md_req),
    .busy   (busy),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void expect_op(input string nm, input logic [31:0] h,
                                    input logic [31:0] l, input int c);
    q.push_back('{hi: h, lo: l, cyc: c, name: nm});
  endfunction

  // Monitor: a busy falling edge is the completion event; compare against the queue.
  task automatic monitor();
    logic prev_busy = 1'b0;
    int   cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) cyc++;
      else if (prev_busy) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_completion: got hi=%h lo=%h after %0d busy cycles, required no completion",
                   hi, lo, cyc);
        end else begin
          e = q.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_busy_cycles"}, 32'(cyc), 32'(e.cyc));
        end
        cyc = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the command for exactly one sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    mdop  = op;
    numa  = a;
    numb  = b;
    tick();
    start = 1'b0;
    mdop  = 3'd6;
    numa  = $urandom;
    numb  = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    // Signed multiply: -3 * 5 = -15
    expect_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy_after_accept", 32'(busy), 32'd1);
    chk("mult_hi_held_while_busy", hi, 32'd0);
    wait_idle();

    // Back-to-back: DIVU in first idle cycle, then signed DIV
    expect_op("divu", 32'd2, 32'd3, 10);
    issue(3'd3, 32'd17, 32'd5);
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    wait_idle();
    expect_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();

    // MTHI/MTLO preset, then divide by zero keeps them
    issue(3'd4, 32'h0000_AAAA, 32'h1234_5678);
    chk("mthi_hi", hi, 32'h0000_AAAA);
    chk("mthi_not_busy", 32'(busy), 32'd0);
    chk("mthi_lo_kept", lo, 32'hFFFF_FFFD);
    issue(3'd5, 32'h0000_BBBB, 32'h1234_5678);
    chk("mtlo_lo", lo, 32'h0000_BBBB);
    chk("mtlo_hi_kept", hi, 32'h0000_AAAA);
    expect_op("div_zero", 32'h0000_AAAA, 32'h0000_BBBB, 10);
    issue(3'd2, 32'h0000_1234, 32'd0);
    repeat (4) tick();
    chk("div_zero_hi_mid", hi, 32'h0000_AAAA);
    wait_idle();

    // MULTU with a DIVU attempted in busy cycle 2: ignored
    expect_op("multu", 32'h0000_0001, 32'h0001_0000, 5);
    issue(3'd1, 32'h0001_0000, 32'h0001_0001);
    tick();
    issue(3'd3, 32'd100, 32'd7);
    chk("ignored_start_busy", 32'(busy), 32'd1);
    wait_idle();
    repeat (3) tick();
    chk("ignored_start_lo", lo, 32'h0001_0000);
    chk("ignored_start_hi", hi, 32'h0000_0001);

    // Stall behaviour
    md_req = 1'b1;
    @(negedge clk);
    chk("stall_idle", 32'(stall), 32'd0);
    tick();
    start = 1'b1; mdop = 3'd4; numa = 32'd0;
    @(negedge clk);
    chk("stall_mthi", 32'(stall), 32'd0);
    tick();
    expect_op("mult_stall", 32'd0, 32'h0000_000C, 5);
    start = 1'b1; mdop = 3'd0; numa = 32'd3; numb = 32'd4;
    @(negedge clk);
    chk("stall_issue", 32'(stall), 32'd1);
    tick();
    start = 1'b0; mdop = 3'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_busy_%0d", k + 1), 32'(stall), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("stall_first_idle", 32'(stall), 32'd0);
    chk("busy_first_idle", 32'(busy), 32'd0);
    md_req = 1'b0;
    tick();

    // Reset in busy cycle 3 of DIV aborts it
    expect_op("div_abort", 32'd0, 32'd0, 3);
    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    reset = 1'b1;
    repeat (15) tick();
    chk("abort_no_commit_busy", 32'(busy), 32'd0);
    chk("abort_no_commit_lo", lo, 32'd0);
    chk("abort_no_commit_hi", hi, 32'd0);

    repeat (3) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
